result_matrix_reader: RTL and testbench
=======================================

RESULT_MATRIX_READER -- requirements
Module: result_matrix_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 7: RAM address width; the matrix holds 2^ADDR_WIDTH words.
REQ-002 Parameter RESULT_WIDTH, default 24: RAM word width.
REQ-003 clock  in  1: single clock; all logic is posedge-triggered.
REQ-004 reset  in  1: synchronous, active-low; low at a posedge resets the block.
REQ-005 start  in  1: one-cycle request to drain the whole result RAM.
REQ-006 expected_sum  in  RESULT_WIDTH: reference sum sampled at start.
REQ-007 addrA, addrB  out  ADDR_WIDTH: registered RAM read addresses.
REQ-008 addrA_value, addrB_value  in  RESULT_WIDTH: RAM read data, valid one cycle after address.
REQ-009 out_valid  out  1: output pair valid.
REQ-010 out_ready  in  1: downstream accepts the pair.
REQ-011 out_dataA, out_dataB  out  RESULT_WIDTH: word 2k and word 2k+1.
REQ-012 busy  out  1: high in every state except IDLE.
REQ-013 done  out  1: one-cycle pulse after the last pair is accepted.
REQ-014 sum_error  out  1: checksum mismatch flag, held until the next start or reset.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, CAPTURE, SEND and DONE.
REQ-016 IDLE->ISSUE on start; the pair index k clears to 0, expected_sum is registered and sum_error clears.
REQ-017 In ISSUE the outputs SHALL be addrA=2k and addrB=2k+1; next state CAPTURE.
REQ-018 In CAPTURE, addrA_value/addrB_value SHALL be registered into out_dataA/out_dataB; next state SEND.
REQ-019 In SEND, out_valid=1; a transfer occurs when out_valid and out_ready are both high at a posedge.
REQ-020 While out_valid=1 and out_ready=0, out_dataA/out_dataB SHALL remain stable.
REQ-021 On transfer with addrB != all-ones, k increments and the FSM goes to ISSUE; with addrB all-ones the FSM goes to DONE.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 Latency: out_valid first rises 3 cycles after start is sampled; each pair takes 3 cycles minimum with out_ready held high.
REQ-024 start SHALL be ignored while busy=1, including in DONE.
REQ-025 out_ready asserted outside SEND SHALL have no effect.
REQ-026 Exactly 2^(ADDR_WIDTH-1) pairs SHALL be emitted per run, with no wrap past the last address.

Reset
REQ-027 On reset: the FSM goes to IDLE; addrA=0, addrB=0, out_dataA=0, out_dataB=0, out_valid=0, done=0, sum_error=0, busy=0, accumulator=0, k=0.
REQ-028 Reset mid-operation SHALL abort the run at the next posedge with no done pulse; a pending output pair is dropped.

Configuration
REQ-029 Macro RESULT_MATRIX_READER_CHECKSUM_EN defined: an accumulator of RESULT_WIDTH bits, modulo 2^RESULT_WIDTH, adds out_dataA+out_dataB on each transfer.
REQ-030 With the macro defined, on entering DONE, sum_error SHALL be set to (accumulator + final pair != registered expected_sum), and the accumulator clears at start.
REQ-031 Macro not defined: no accumulator is built and sum_error is tied to 0; all other behaviour is unchanged.

Verification
REQ-032 ADDR_WIDTH=3, RAM words 1..8, out_ready=1, start -> pairs (1,2),(3,4),(5,6),(7,8); addresses 0/1, 2/3, 4/5, 6/7; done 1 cycle after the 4th transfer.
REQ-033 Same run, out_ready low for 5 cycles during pair (3,4) -> out_data holds (3,4) with out_valid=1; no address advance.
REQ-034 With the checksum macro, expected_sum=36 -> sum_error=0; expected_sum=35 -> sum_error=1 at done; without the macro, sum_error=0 in both cases.
REQ-035 Words 0xFFFFFF in all 8 locations, checksum macro, expected_sum=0xFFFFF8 -> sum_error=0 (wrap-around).
REQ-036 reset low during the 2nd SEND -> next cycle out_valid=0, busy=0, addresses 0; a new start restarts at pair (1,2).
REQ-037 start pulsed during CAPTURE and during DONE -> ignored; the run emits exactly 4 pairs.

Source files
------------

// File: rtl/result_matrix_reader_if.sv
// Handshake and RAM-read bundle between result_matrix_reader (master) and its RAM/consumer (slave).
interface result_matrix_reader_if #(
   parameter int ADDR_WIDTH   = 7,
   parameter int RESULT_WIDTH = 24
);
   logic                    start;
   logic [RESULT_WIDTH-1:0] expected_sum;
   logic [ADDR_WIDTH-1:0]   addrA;
   logic [ADDR_WIDTH-1:0]   addrB;
   logic [RESULT_WIDTH-1:0] addrA_value;
   logic [RESULT_WIDTH-1:0] addrB_value;
   logic                    out_valid;
   logic                    out_ready;
   logic [RESULT_WIDTH-1:0] out_dataA;
   logic [RESULT_WIDTH-1:0] out_dataB;
   logic                    busy;
   logic                    done;
   logic                    sum_error;

   modport master (
      input  start, expected_sum, addrA_value, addrB_value, out_ready,
      output addrA, addrB, out_valid, out_dataA, out_dataB, busy, done, sum_error
   );

   modport slave (
      output start, expected_sum, addrA_value, addrB_value, out_ready,
      input  addrA, addrB, out_valid, out_dataA, out_dataB, busy, done, sum_error
   );
endinterface

// File: rtl/result_matrix_reader.sv
// Drains a result RAM as word pairs (2k, 2k+1) over a valid/ready handshake.
// Optional checksum against expected_sum when RESULT_MATRIX_READER_CHECKSUM_EN is defined.
module result_matrix_reader #(
   parameter int ADDR_WIDTH   = 7,
   parameter int RESULT_WIDTH = 24
) (
   input logic                   clock,
   input logic                   reset,
   result_matrix_reader_if.master bus
);
   // state   | meaning
   // IDLE    | waiting for start
   // ISSUE   | read addresses 2k/2k+1 presented to the RAM
   // CAPTURE | RAM data registered into out_dataA/out_dataB
   // SEND    | out_valid high, waiting for out_ready
   // DONE    | one-cycle done pulse, then IDLE
   localparam int PW = ADDR_WIDTH - 1;

   typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, DONE} state_t;

   state_t        state;
   logic [PW-1:0] k;
   logic [PW-1:0] k_next;

   assign k_next = k + 1'b1;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         k             <= '0;
         bus.addrA     <= '0;
         bus.addrB     <= '0;
         bus.out_dataA <= '0;
         bus.out_dataB <= '0;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state     <= ISSUE;
                  k         <= '0;
                  bus.addrA <= '0;
                  bus.addrB <= ADDR_WIDTH'(1);
                  bus.busy  <= 1'b1;
               end
            end
            ISSUE: state <= CAPTURE;
            CAPTURE: begin
               bus.out_dataA <= bus.addrA_value;
               bus.out_dataB <= bus.addrB_value;
               bus.out_valid <= 1'b1;
               state         <= SEND;
            end
            SEND: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  // last pair sits at the all-ones address; stop instead of wrapping
                  if (&bus.addrB) begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end else begin
                     k         <= k_next;
                     bus.addrA <= {k_next, 1'b0};
                     bus.addrB <= {k_next, 1'b1};
                     state     <= ISSUE;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RESULT_MATRIX_READER_CHECKSUM_EN
   logic [RESULT_WIDTH-1:0] acc;
   logic [RESULT_WIDTH-1:0] exp_sum;
   logic [RESULT_WIDTH-1:0] pair_sum;

   assign pair_sum = acc + bus.out_dataA + bus.out_dataB;

   always_ff @(posedge clock) begin
      if (!reset) begin
         acc           <= '0;
         exp_sum       <= '0;
         bus.sum_error <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         acc           <= '0;
         exp_sum       <= bus.expected_sum;
         bus.sum_error <= 1'b0;
      end else if (state == SEND && bus.out_ready) begin
         acc <= pair_sum;
         if (&bus.addrB) bus.sum_error <= (pair_sum != exp_sum);
      end
   end
`else
   assign bus.sum_error = 1'b0;
`endif
endmodule

// File: tb/tb_result_matrix_reader.sv
// Directed bench for result_matrix_reader with an 8-word registered RAM model (ADDR_WIDTH=3).
module tb_result_matrix_reader;
   localparam int AW = 3;
   localparam int RW = 24;

`ifdef RESULT_MATRIX_READER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [RW-1:0] mem [8];
   int n_checks = 0;
   int n_errors = 0;

   result_matrix_reader_if #(.ADDR_WIDTH(AW), .RESULT_WIDTH(RW)) bus ();

   result_matrix_reader #(.ADDR_WIDTH(AW), .RESULT_WIDTH(RW)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // synchronous RAM: data follows the address by one clock
   always @(posedge clk) begin
      bus.addrA_value <= mem[bus.addrA];
      bus.addrB_value <= mem[bus.addrB];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_matrix(input logic [RW-1:0] es, input int stall_pair, input int stall_n,
                             input bit glitch, input bit exp_err);
      int cyc = 0;
      int npairs = 0;
      int ndone = 0;
      int first_valid = -1;
      int last_xfer = -1;
      int done_cyc = -1;
      int prev_rise = -1;
      int stall_left = stall_n;
      int extra = 0;
      bit prev_valid = 1'b0;
      @(negedge clk);
      bus.start        = 1'b1;
      bus.expected_sum = es;
      while (ndone == 0 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         bus.start     = (glitch && cyc == 2);
         bus.out_ready = 1'b1;
         if (cyc == 1) begin
            check("busy_after_start", bus.busy, 1);
            check("sum_error_cleared", bus.sum_error, 0);
         end
         if (bus.out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (!prev_valid) begin
               if (stall_n == 0 && prev_rise >= 0) check("pair_period", cyc - prev_rise, 3);
               prev_rise = cyc;
            end
            check("addrA", bus.addrA, 2 * npairs);
            check("addrB", bus.addrB, 2 * npairs + 1);
            check("dataA", bus.out_dataA, mem[2 * npairs]);
            check("dataB", bus.out_dataB, mem[2 * npairs + 1]);
            if (npairs == stall_pair && stall_left > 0) begin
               bus.out_ready = 1'b0;
               stall_left--;
            end else begin
               npairs++;
               last_xfer = cyc;
            end
         end
         prev_valid = bus.out_valid;
         if (bus.done) begin
            ndone++;
            done_cyc = cyc;
            check("sum_error_at_done", bus.sum_error, exp_err);
            if (glitch) bus.start = 1'b1;
         end
      end
      check("done_seen", ndone, 1);
      check("first_valid_latency", first_valid, 3);
      check("pair_count", npairs, 4);
      check("done_after_last", done_cyc - last_xfer, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.out_valid || bus.busy || bus.done) extra++;
      end
      check("quiet_after_done", extra, 0);
      check("sum_error_held", bus.sum_error, exp_err);
   endtask

   task automatic abort_run();
      int cyc = 0;
      int rises = 0;
      bit prev_valid = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      while (rises < 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         bus.start     = 1'b0;
         bus.out_ready = 1'b1;
         if (bus.out_valid && !prev_valid) rises++;
         prev_valid = bus.out_valid;
      end
      check("abort_second_send", rises, 2);
      rst = 1'b0;
      @(negedge clk);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_addrA", bus.addrA, 0);
      check("abort_addrB", bus.addrB, 0);
      check("abort_done", bus.done, 0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_idle_done", bus.done, 0);
   endtask

   initial begin
      bus.start        = 1'b0;
      bus.expected_sum = '0;
      bus.out_ready    = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = RW'(i + 1);
      repeat (3) @(negedge clk);
      check("rst_addrA", bus.addrA, 0);
      check("rst_addrB", bus.addrB, 0);
      check("rst_dataA", bus.out_dataA, 0);
      check("rst_dataB", bus.out_dataB, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_sum_error", bus.sum_error, 0);
      rst = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("ready_in_idle_no_effect", bus.out_valid, 0);

      run_matrix(24'd36, -1, 0, 1'b0, 1'b0);
      run_matrix(24'd35, 1, 5, 1'b0, CSUM);
      run_matrix(24'd36, -1, 0, 1'b1, 1'b0);
      abort_run();
      run_matrix(24'd36, -1, 0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) mem[i] = 24'hFFFFFF;
      run_matrix(24'hFFFFF8, -1, 0, 1'b0, 1'b0);
      run_matrix(24'hFFFFF7, -1, 0, 1'b0, CSUM);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
